// File: rtl/io_mmio_responder.sv
// Memory-mapped I/O responder for the core's load/store port.
// Decodes the 0x8xxx_xxxx region and serves the UART RX/TX FIFOs, the
// status word, and the cycle / retired-instruction counters.
// Read data is registered and returned one cycle after the request.
module io_mmio_responder #(
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wbe,
  input  logic        re,
  input  logic        inst_retire,
  output logic [31:0] rdata,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);

  localparam logic [7:0] ADDR_STATUS  = 8'h00;
  localparam logic [7:0] ADDR_RX_DATA = 8'h04;
  localparam logic [7:0] ADDR_TX_DATA = 8'h08;
  localparam logic [7:0] ADDR_CYCLE   = 8'h10;
  localparam logic [7:0] ADDR_INST    = 8'h14;
  localparam logic [7:0] ADDR_CNT_CLR = 8'h18;

  logic        sel;
  logic [7:0]  reg_off;
  logic        wr;
  logic        rd;
  logic        unused_bits;

  assign sel     = (addr[31:28] == 4'h8);
  assign reg_off = addr[7:0];
  assign wr      = sel && (wbe != 4'b0000);
  assign rd      = sel && re;

  // Upper address bits and upper store data are don't-care for this block.
  assign unused_bits = &{addr[27:8], wdata[31:8]};

  // RX FIFO: pointers carry one extra wrap bit so full and empty differ.
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RX_AW:0] rx_wptr, rx_rptr;
  logic           rx_empty, rx_full, rx_push, rx_pop;
  logic [7:0]     rx_head;
  logic           rx_overflow;
  logic           stat_rd;

  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = (rx_wptr[RX_AW] != rx_rptr[RX_AW]) &&
                    (rx_wptr[RX_AW-1:0] == rx_rptr[RX_AW-1:0]);
  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && !rx_full;
  assign rx_pop   = rd && (reg_off == ADDR_RX_DATA) && !rx_empty;
  assign rx_head  = rx_mem[rx_rptr[RX_AW-1:0]];
  assign stat_rd  = rd && (reg_off == ADDR_STATUS);

  // TX FIFO: a write at full still lands when the same edge pops the head.
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TX_AW:0] tx_wptr, tx_rptr;
  logic           tx_empty, tx_full, tx_push, tx_pop;

  assign tx_empty = (tx_wptr == tx_rptr);
  assign tx_full  = (tx_wptr[TX_AW] != tx_rptr[TX_AW]) &&
                    (tx_wptr[TX_AW-1:0] == tx_rptr[TX_AW-1:0]);
  assign tx_valid = !tx_empty;
  assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rptr[TX_AW-1:0]];
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_push  = wr && (reg_off == ADDR_TX_DATA) && (!tx_full || tx_pop);

  logic [31:0] cycle_cnt, inst_cnt;
  logic        cnt_clr;
  logic [31:0] rd_next;

  assign cnt_clr = wr && (reg_off == ADDR_CNT_CLR);

  // FIFO storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr[RX_AW-1:0]] <= rx_data;
    if (tx_push) tx_mem[tx_wptr[TX_AW-1:0]] <= wdata[7:0];
  end

  // FIFO pointers and the sticky RX overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wptr     <= '0;
      rx_rptr     <= '0;
      tx_wptr     <= '0;
      tx_rptr     <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      if (rx_valid && rx_full) rx_overflow <= 1'b1;
      else if (stat_rd)        rx_overflow <= 1'b0;
    end
  end

  // Free-running cycle counter and retired-instruction counter; clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= 32'h0;
      inst_cnt  <= 32'h0;
    end else if (cnt_clr) begin
      cycle_cnt <= 32'h0;
      inst_cnt  <= 32'h0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'h1;
      inst_cnt  <= inst_cnt + {31'h0, inst_retire};
    end
  end

  // Read mux over pre-edge state; unmapped and unselected reads give 0.
  always_comb begin
    rd_next = 32'h0;
    if (sel) begin
      case (reg_off)
        ADDR_STATUS:  rd_next = {29'h0, rx_overflow, !rx_empty, !tx_full};
        ADDR_RX_DATA: rd_next = {24'h0, (rx_empty ? 8'h00 : rx_head)};
        ADDR_CYCLE:   rd_next = cycle_cnt;
        ADDR_INST:    rd_next = inst_cnt;
        default:      rd_next = 32'h0;
      endcase
    end
  end

  // Read data register: updates only on a load request, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= 32'h0;
    else if (re) rdata <= rd_next;
  end

endmodule
